// File: rtl/result_pipe.sv
// Result pipeline EXMA->MAMO->MOWB feeding operand bypass and GP/SR write ports; optional RESULT_PIPE_PERF_EN adds perf counters.
// Latency: EX result reaches the register-file write port 3 edges later; iw_stall freezes every stage and suppresses writes.
module result_pipe #(
   parameter int HBIT_DATA     = 15,
   parameter int HBIT_TGT_GP   = 3,
   parameter int HBIT_SRC_GP   = 3,
   parameter int HBIT_TGT_SR   = 3,
   parameter int LOAD_FWD_MAMO = 0
) (
   input  logic                   iw_clk,
   input  logic                   iw_rst_n,
   input  logic                   iw_stall,
   input  logic                   iw_flush,
   input  logic                   iw_ex_valid,
   input  logic [HBIT_TGT_GP:0]   iw_ex_tgt_gp,
   input  logic                   iw_ex_tgt_gp_we,
   input  logic [HBIT_TGT_SR:0]   iw_ex_tgt_sr,
   input  logic                   iw_ex_tgt_sr_we,
   input  logic                   iw_ex_is_load,
   input  logic [HBIT_DATA:0]     iw_ex_result,
   input  logic [HBIT_DATA:0]     iw_mem_rdata,
   input  logic [HBIT_SRC_GP:0]   iw_id_src_gp,
   input  logic [HBIT_TGT_GP:0]   iw_id_tgt_gp,
   output logic [HBIT_TGT_GP:0]   ow_tgt_exma_gp,
   output logic                   ow_tgt_exma_gp_we,
   output logic [HBIT_TGT_SR:0]   ow_tgt_exma_sr,
   output logic                   ow_tgt_exma_sr_we,
   output logic [HBIT_TGT_GP:0]   ow_tgt_mamo_gp,
   output logic                   ow_tgt_mamo_gp_we,
   output logic [HBIT_TGT_SR:0]   ow_tgt_mamo_sr,
   output logic                   ow_tgt_mamo_sr_we,
   output logic [HBIT_TGT_GP:0]   ow_tgt_mowb_gp,
   output logic                   ow_tgt_mowb_gp_we,
   output logic [HBIT_TGT_SR:0]   ow_tgt_mowb_sr,
   output logic                   ow_tgt_mowb_sr_we,
   output logic [HBIT_DATA:0]     ow_exma_result,
   output logic [HBIT_DATA:0]     ow_mamo_result,
   output logic [HBIT_DATA:0]     ow_mowb_result,
   output logic [HBIT_TGT_GP:0]   ow_gp_wr_addr,
   output logic                   ow_gp_wr_en,
   output logic [HBIT_DATA:0]     ow_gp_wr_data,
   output logic [HBIT_TGT_SR:0]   ow_sr_wr_addr,
   output logic                   ow_sr_wr_en,
   output logic [HBIT_DATA:0]     ow_sr_wr_data,
   output logic                   ow_load_hazard
`ifdef RESULT_PIPE_PERF_EN
   ,
   output logic [15:0]            ow_perf_hazard_cycles,
   output logic [15:0]            ow_perf_retired
`endif
);

   localparam bit FWD_MAMO = (LOAD_FWD_MAMO != 0);
   localparam int HW = (HBIT_SRC_GP > HBIT_TGT_GP) ? HBIT_SRC_GP : HBIT_TGT_GP;

   typedef struct packed {
      logic                 valid;
      logic [HBIT_TGT_GP:0] tgt_gp;
      logic                 gp_we;
      logic [HBIT_TGT_SR:0] tgt_sr;
      logic                 sr_we;
      logic                 is_load;
      logic [HBIT_DATA:0]   result;
   } stage_t;

   // Load data is already merged into the result on entry to MOWB, so the load flag is not carried there.
   typedef struct packed {
      logic                 valid;
      logic [HBIT_TGT_GP:0] tgt_gp;
      logic                 gp_we;
      logic [HBIT_TGT_SR:0] tgt_sr;
      logic                 sr_we;
      logic [HBIT_DATA:0]   result;
   } wb_t;

   stage_t exma, mamo, ex_entry;
   wb_t    mowb, mowb_nxt;
   logic   ex_live;

   always_comb begin
      ex_live  = iw_ex_valid & ~iw_flush;
      ex_entry = '0;
      if (ex_live) begin
         ex_entry.valid   = 1'b1;
         ex_entry.tgt_gp  = iw_ex_tgt_gp;
         ex_entry.gp_we   = iw_ex_tgt_gp_we;
         ex_entry.tgt_sr  = iw_ex_tgt_sr;
         ex_entry.sr_we   = iw_ex_tgt_sr_we;
         ex_entry.is_load = iw_ex_is_load;
         ex_entry.result  = iw_ex_result;
      end
   end

   always_comb begin
      mowb_nxt.valid  = mamo.valid;
      mowb_nxt.tgt_gp = mamo.tgt_gp;
      mowb_nxt.gp_we  = mamo.gp_we & mamo.valid;
      mowb_nxt.tgt_sr = mamo.tgt_sr;
      mowb_nxt.sr_we  = mamo.sr_we & mamo.valid;
      mowb_nxt.result = mamo.is_load ? iw_mem_rdata : mamo.result;
   end

   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) begin
         exma <= '0;
         mamo <= '0;
         mowb <= '0;
      end else if (!iw_stall) begin
         exma <= ex_entry;
         mamo <= exma;
         mowb <= mowb_nxt;
      end else if (iw_flush) begin
         exma <= '0;
      end
   end

   // Forward-valid: a load in EXMA has no data yet; in MAMO only if memory data is bypassed.
   always_comb begin
      ow_tgt_exma_gp    = exma.tgt_gp;
      ow_tgt_exma_sr    = exma.tgt_sr;
      ow_tgt_exma_gp_we = exma.valid & exma.gp_we & ~exma.is_load;
      ow_tgt_exma_sr_we = exma.valid & exma.sr_we & ~exma.is_load;
      ow_exma_result    = exma.result;

      ow_tgt_mamo_gp    = mamo.tgt_gp;
      ow_tgt_mamo_sr    = mamo.tgt_sr;
      ow_tgt_mamo_gp_we = mamo.valid & mamo.gp_we & (~mamo.is_load | FWD_MAMO);
      ow_tgt_mamo_sr_we = mamo.valid & mamo.sr_we & (~mamo.is_load | FWD_MAMO);
      ow_mamo_result    = (FWD_MAMO && mamo.is_load) ? iw_mem_rdata : mamo.result;

      ow_tgt_mowb_gp    = mowb.tgt_gp;
      ow_tgt_mowb_sr    = mowb.tgt_sr;
      ow_tgt_mowb_gp_we = mowb.valid & mowb.gp_we;
      ow_tgt_mowb_sr_we = mowb.valid & mowb.sr_we;
      ow_mowb_result    = mowb.result;
   end

   always_comb begin
      ow_gp_wr_addr = mowb.tgt_gp;
      ow_gp_wr_data = mowb.result;
      ow_gp_wr_en   = mowb.valid & mowb.gp_we & ~iw_stall;
      ow_sr_wr_addr = mowb.tgt_sr;
      ow_sr_wr_data = mowb.result;
      ow_sr_wr_en   = mowb.valid & mowb.sr_we & ~iw_stall;
   end

   logic [HW:0] id_src_x, id_tgt_x, exma_tgt_x, mamo_tgt_x;
   logic        hz_exma, hz_mamo;

   always_comb begin
      id_src_x   = (HW+1)'(iw_id_src_gp);
      id_tgt_x   = (HW+1)'(iw_id_tgt_gp);
      exma_tgt_x = (HW+1)'(exma.tgt_gp);
      mamo_tgt_x = (HW+1)'(mamo.tgt_gp);
      hz_exma = exma.valid & exma.is_load & exma.gp_we &
                ((exma_tgt_x == id_src_x) | (exma_tgt_x == id_tgt_x));
      hz_mamo = mamo.valid & mamo.is_load & mamo.gp_we &
                ((mamo_tgt_x == id_src_x) | (mamo_tgt_x == id_tgt_x));
      ow_load_hazard = hz_exma | (hz_mamo & ~FWD_MAMO);
   end

`ifdef RESULT_PIPE_PERF_EN
   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) begin
         ow_perf_hazard_cycles <= '0;
         ow_perf_retired       <= '0;
      end else begin
         if (ow_load_hazard && ow_perf_hazard_cycles != 16'hFFFF)
            ow_perf_hazard_cycles <= ow_perf_hazard_cycles + 16'd1;
         if ((ow_gp_wr_en || ow_sr_wr_en) && ow_perf_retired != 16'hFFFF)
            ow_perf_retired <= ow_perf_retired + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_result_pipe.sv
// Directed bench for result_pipe: two instances cover LOAD_FWD_MAMO=0 (d0) and =1 (d1).
module tb_result_pipe;

   logic        clk, rst_n, stall, flush;
   logic        ex_valid, ex_gp_we, ex_sr_we, ex_is_load;
   logic [3:0]  ex_tgt_gp, ex_tgt_sr, id_src_gp, id_tgt_gp;
   logic [15:0] ex_result, mem_rdata;

   logic [3:0]  a_exma_gp[2], a_mamo_gp[2], a_mowb_gp[2], a_exma_sr[2], a_mamo_sr[2], a_mowb_sr[2];
   logic        a_exma_gp_we[2], a_mamo_gp_we[2], a_mowb_gp_we[2];
   logic        a_exma_sr_we[2], a_mamo_sr_we[2], a_mowb_sr_we[2];
   logic [15:0] a_exma_res[2], a_mamo_res[2], a_mowb_res[2];
   logic [3:0]  gp_addr[2], sr_addr[2];
   logic        gp_en[2], sr_en[2], hazard[2];
   logic [15:0] gp_data[2], sr_data[2];
`ifdef RESULT_PIPE_PERF_EN
   logic [15:0] perf_hz[2], perf_ret[2];
`endif

   int n_pass = 0;
   int n_chk  = 0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      result_pipe #(.LOAD_FWD_MAMO(g)) dut (
         .iw_clk(clk), .iw_rst_n(rst_n), .iw_stall(stall), .iw_flush(flush),
         .iw_ex_valid(ex_valid), .iw_ex_tgt_gp(ex_tgt_gp), .iw_ex_tgt_gp_we(ex_gp_we),
         .iw_ex_tgt_sr(ex_tgt_sr), .iw_ex_tgt_sr_we(ex_sr_we), .iw_ex_is_load(ex_is_load),
         .iw_ex_result(ex_result), .iw_mem_rdata(mem_rdata),
         .iw_id_src_gp(id_src_gp), .iw_id_tgt_gp(id_tgt_gp),
         .ow_tgt_exma_gp(a_exma_gp[g]), .ow_tgt_exma_gp_we(a_exma_gp_we[g]),
         .ow_tgt_exma_sr(a_exma_sr[g]), .ow_tgt_exma_sr_we(a_exma_sr_we[g]),
         .ow_tgt_mamo_gp(a_mamo_gp[g]), .ow_tgt_mamo_gp_we(a_mamo_gp_we[g]),
         .ow_tgt_mamo_sr(a_mamo_sr[g]), .ow_tgt_mamo_sr_we(a_mamo_sr_we[g]),
         .ow_tgt_mowb_gp(a_mowb_gp[g]), .ow_tgt_mowb_gp_we(a_mowb_gp_we[g]),
         .ow_tgt_mowb_sr(a_mowb_sr[g]), .ow_tgt_mowb_sr_we(a_mowb_sr_we[g]),
         .ow_exma_result(a_exma_res[g]), .ow_mamo_result(a_mamo_res[g]),
         .ow_mowb_result(a_mowb_res[g]),
         .ow_gp_wr_addr(gp_addr[g]), .ow_gp_wr_en(gp_en[g]), .ow_gp_wr_data(gp_data[g]),
         .ow_sr_wr_addr(sr_addr[g]), .ow_sr_wr_en(sr_en[g]), .ow_sr_wr_data(sr_data[g]),
         .ow_load_hazard(hazard[g])
`ifdef RESULT_PIPE_PERF_EN
         ,
         .ow_perf_hazard_cycles(perf_hz[g]), .ow_perf_retired(perf_ret[g])
`endif
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] tgp, input logic gwe, input logic [3:0] tsr,
                        input logic swe, input logic ld, input logic [15:0] res);
      ex_valid = 1'b1; ex_tgt_gp = tgp; ex_gp_we = gwe; ex_tgt_sr = tsr;
      ex_sr_we = swe; ex_is_load = ld; ex_result = res;
   endtask

   task automatic idle_ex();
      ex_valid = 1'b0; ex_tgt_gp = '0; ex_gp_we = 1'b0; ex_tgt_sr = '0;
      ex_sr_we = 1'b0; ex_is_load = 1'b0; ex_result = '0;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      idle_ex();
      mem_rdata = '0; id_src_gp = '0; id_tgt_gp = 4'hF;
      step();
      check("rst_mowb_we", a_mowb_gp_we[0], 0);
      check("rst_gp_en", gp_en[0], 0);
      check("rst_hazard", hazard[0], 0);
      step();
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) step();
      check("idle_we", {a_exma_gp_we[0], a_mamo_gp_we[0], a_mowb_gp_we[0], a_mowb_sr_we[0]}, 0);
      check("idle_wr", {gp_en[0], sr_en[0], gp_en[1], sr_en[1]}, 0);
      check("idle_hazard", {hazard[0], hazard[1]}, 0);

      // ALU op to r3
      issue(4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 16'h1234);
      step();
      idle_ex();
      check("alu_exma_tgt", a_exma_gp[0], 3);
      check("alu_exma_we", a_exma_gp_we[0], 1);
      check("alu_exma_res", a_exma_res[0], 16'h1234);
      check("alu_wr_early", gp_en[0], 0);
      step();
      check("alu_mamo", {a_mamo_gp[0], a_mamo_gp_we[0], a_exma_gp_we[0]}, {4'd3, 1'b1, 1'b0});
      step();
      check("alu_mowb_we", a_mowb_gp_we[0], 1);
      check("alu_gp_wr", {gp_en[0], gp_addr[0], gp_data[0]}, {1'b1, 4'd3, 16'h1234});
      check("alu_no_sr", sr_en[0], 0);
      step();
      check("alu_wr_once", gp_en[0], 0);

      // Load to r5 with decode reading r5
      id_src_gp = 4'd5;
      mem_rdata = 16'hBEEF;
      issue(4'd5, 1'b1, 4'd0, 1'b0, 1'b1, 16'h7777);
      #1;
      check("ld_hz_pre", {hazard[0], hazard[1]}, 0);
      step();
      idle_ex();
      check("ld_hz_exma", {hazard[0], hazard[1]}, 2'b11);
      check("ld_exma_we", {a_exma_gp_we[0], a_exma_gp_we[1]}, 0);
      step();
      check("ld_hz_mamo", {hazard[0], hazard[1]}, 2'b10);
      check("ld_mamo_we", {a_mamo_gp_we[0], a_mamo_gp_we[1]}, 2'b01);
      check("ld_mamo_res_fwd", a_mamo_res[1], 16'hBEEF);
      check("ld_mamo_res_nofwd", a_mamo_res[0], 16'h7777);
      step();
      mem_rdata = 16'h0000;
      #1;
      check("ld_hz_mowb", {hazard[0], hazard[1]}, 0);
      check("ld_mowb_res", {a_mowb_res[0], a_mowb_res[1]}, {16'hBEEF, 16'hBEEF});
      check("ld_gp_wr", {gp_en[0], gp_addr[0], gp_data[0]}, {1'b1, 4'd5, 16'hBEEF});
      id_src_gp = 4'd0;
      step();

      // Hazard through the decode target operand; no hazard on a non-load
      id_tgt_gp = 4'd9;
      issue(4'd9, 1'b1, 4'd0, 1'b0, 1'b1, 16'h0);
      step();
      check("ld_hz_tgt", hazard[0], 1);
      issue(4'd9, 1'b1, 4'd0, 1'b0, 1'b0, 16'h0);
      step();
      idle_ex();
      check("alu_no_hz", {hazard[0], hazard[1]}, 2'b10);
      id_tgt_gp = 4'hF;
      for (int i = 0; i < 3; i++) step();

      // Stall with SR+GP writer in MOWB, then flush under stall
      issue(4'd7, 1'b1, 4'd2, 1'b1, 1'b0, 16'h00A5);
      step();
      issue(4'd1, 1'b1, 4'd0, 1'b0, 1'b0, 16'h0042);
      step();
      issue(4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 16'h0033);
      step();
      idle_ex();
      check("st_mowb_pre", {a_mowb_sr[0], a_mowb_sr_we[0]}, {4'd2, 1'b1});
      stall = 1'b1;
      #1;
      check("st_sr_en0", {sr_en[0], gp_en[0]}, 0);
      for (int i = 0; i < 3; i++) begin
         if (i == 2) flush = 1'b1;
         step();
         check("st_sr_en", sr_en[0], 0);
         check("st_mowb_hold", {a_mowb_sr[0], a_mowb_gp[0], a_mowb_res[0]}, {4'd2, 4'd7, 16'h00A5});
      end
      check("fl_exma", a_exma_gp_we[0], 0);
      check("fl_mamo_hold", {a_mamo_gp[0], a_mamo_gp_we[0], a_mamo_res[0]}, {4'd1, 1'b1, 16'h0042});
      flush = 1'b0;
      stall = 1'b0;
      #1;
      check("st_rel_sr", {sr_en[0], sr_addr[0], sr_data[0]}, {1'b1, 4'd2, 16'h00A5});
      check("st_rel_gp", {gp_en[0], gp_addr[0]}, {1'b1, 4'd7});
      step();
      check("st_next", {sr_en[0], gp_en[0], gp_addr[0], gp_data[0]}, {1'b0, 1'b1, 4'd1, 16'h0042});
      step();
      check("fl_bubble", gp_en[0], 0);

      // Async reset with three entries in flight
      for (int i = 0; i < 3; i++) begin
         issue(4'(i + 10), 1'b1, 4'd0, 1'b0, 1'b0, 16'(16'hC000 + i));
         step();
      end
      idle_ex();
      check("ar_pre", {a_exma_gp_we[0], a_mamo_gp_we[0], a_mowb_gp_we[0]}, 3'b111);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_we", {a_exma_gp_we[0], a_mamo_gp_we[0], a_mowb_gp_we[0]}, 0);
      check("ar_res", {a_exma_res[0], a_mamo_res[0], a_mowb_res[0]}, 0);
      check("ar_wr", {gp_en[0], gp_addr[0], gp_data[0]}, 0);
`ifdef RESULT_PIPE_PERF_EN
      check("ar_perf", {perf_hz[0], perf_ret[0]}, 0);
`endif
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("ar_no_wr", {gp_en[0], sr_en[0], gp_en[1], sr_en[1]}, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/result_pipe.md
Name: result_pipe

Overview:
Producer side of the operand-bypass interface. Carries each EX result with its GP/SR target and write enables through three registered stages: EXMA, MAMO and MOWB. It publishes the per-stage target, write-enable and result buses that the forwarding logic compares against, and it drives the GP and SR register-file write ports from MOWB. It also substitutes memory load data in MAMO->MOWB and raises a load-use hazard for the decode/issue stall logic.

Parameters:
LOAD_FWD_MAMO, 0, 1 = forward memory read data directly from MAMO when a load sits there (the hazard covers EXMA only); 0 = loads are forwardable from MOWB only.

Ports:
iw_clk  in  1  core clock, all state on rising edge
iw_rst_n  in  1  asynchronous active-low reset
iw_stall  in  1  hold all stages
iw_flush  in  1  kill the incoming EX entry (bubble into EXMA)
iw_ex_valid  in  1  EX has a result this cycle
iw_ex_tgt_gp  in  HBIT_TGT_GP+1  EX GP target
iw_ex_tgt_gp_we  in  1  EX writes GP
iw_ex_tgt_sr  in  HBIT_TGT_SR+1  EX SR target
iw_ex_tgt_sr_we  in  1  EX writes SR
iw_ex_is_load  in  1  result comes from memory, not the ALU
iw_ex_result  in  HBIT_DATA+1  ALU result
iw_mem_rdata  in  HBIT_DATA+1  load data, valid while a load occupies MAMO
iw_id_src_gp  in  HBIT_SRC_GP+1  decode GP source, used for the hazard check
iw_id_tgt_gp  in  HBIT_TGT_GP+1  decode GP target read as an operand
ow_tgt_{exma,mamo,mowb}_gp  out  HBIT_TGT_GP+1  stage GP target
ow_tgt_{exma,mamo,mowb}_gp_we  out  1  stage GP forward-valid
ow_tgt_{exma,mamo,mowb}_sr  out  HBIT_TGT_SR+1  stage SR target
ow_tgt_{exma,mamo,mowb}_sr_we  out  1  stage SR forward-valid
ow_{exma,mamo,mowb}_result  out  HBIT_DATA+1  stage result
ow_gp_wr_addr / ow_gp_wr_en / ow_gp_wr_data  out  HBIT_TGT_GP+1 / 1 / HBIT_DATA+1  GP register-file write port
ow_sr_wr_addr / ow_sr_wr_en / ow_sr_wr_data  out  HBIT_TGT_SR+1 / 1 / HBIT_DATA+1  SR register-file write port
ow_load_hazard  out  1  decode must stall

Behaviour:
- Reset (async, iw_rst_n=0): every stage is invalid. All targets, results, we and is_load bits are 0. All outputs are 0. Reset is honoured mid-stall and mid-load; in-flight entries are discarded.
- Each stage holds: valid, tgt_gp, gp_we, tgt_sr, sr_we, is_load, result. Stored we bits are ANDed with valid.
- Rising edge with iw_stall=0:
  - EXMA <= EX entry, or a bubble if iw_flush=1 or iw_ex_valid=0.
  - MAMO <= EXMA.
  - MOWB <= MAMO. If the MAMO entry is a load, the MOWB result is iw_mem_rdata; otherwise it is the MAMO result.
- Rising edge with iw_stall=1: all stages hold. If iw_flush=1 at the same time, EXMA is cleared to a bubble; MAMO and MOWB still hold.
- Forward-valid outputs:
  - EXMA: exma_*_we = we & ~is_load.
  - MAMO: mamo_*_we = we & (~is_load | LOAD_FWD_MAMO). When LOAD_FWD_MAMO=1 and MAMO holds a load, ow_mamo_result = iw_mem_rdata.
  - MOWB: mowb_*_we = we.
- Write ports: ow_gp_wr_en = mowb gp_we & ~iw_stall; ow_sr_wr_en = mowb sr_we & ~iw_stall. Address and data come from MOWB. Each retiring entry writes exactly once, on the edge it leaves MOWB.
- ow_load_hazard (combinational) = OR over EXMA, and over MAMO only when LOAD_FWD_MAMO=0, of (is_load & gp_we & (tgt_gp==iw_id_src_gp | tgt_gp==iw_id_tgt_gp)).
- GP and SR targets are independent. An entry may write both in the same retirement.
- Latency: EX -> register-file write is 3 edges when not stalled.

Optional Feature:
RESULT_PIPE_PERF_EN
- Defined: adds 16-bit outputs ow_perf_hazard_cycles (counts cycles with ow_load_hazard=1) and ow_perf_retired (counts edges where gp_wr_en|sr_wr_en).
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset released, no EX valid for 5 cycles -> all we outputs 0, write ports idle, hazard 0.
- Issue ALU op tgt_gp=3, result 16'h1234 -> ow_tgt_exma_gp=3 with we=1 next cycle, then MAMO, then MOWB. ow_gp_wr_en=1 addr 3 data 16'h1234 exactly one cycle; no SR write.
- Load tgt_gp=5, iw_mem_rdata=16'hBEEF, LOAD_FWD_MAMO=0, decode src_gp=5 -> ow_load_hazard=1 for 2 cycles, exma/mamo gp_we=0. MOWB result 16'hBEEF and GP write of 16'hBEEF to r5.
- Same load with LOAD_FWD_MAMO=1 -> hazard 1 cycle only. MAMO we=1 with result 16'hBEEF.
- Stall 3 cycles with entry tgt_sr=2 in MOWB -> ow_sr_wr_en=0 during the stall, then a single write after release. iw_flush with stall -> EXMA bubble, MAMO/MOWB unchanged.
- Assert iw_rst_n=0 with 3 valid entries in flight -> all outputs 0 immediately (async); no writes after release.
